// File: rtl/prio_fifo_sched_if.sv
// Scheduler bus: per-priority FIFO heads with their pop strobes, plus the
// registered valid/ready word stream toward the SRAM write path.
interface prio_fifo_sched_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_PRIO = 8
);
    logic [NUM_PRIO-1:0]        fifo_ready;
    logic [NUM_PRIO-1:0]        fifo_sop;
    logic [NUM_PRIO-1:0]        fifo_eop;
    logic [NUM_PRIO*DATA_W-1:0] fifo_data;
    logic [NUM_PRIO-1:0]        next_data;
    logic                       out_vld;
    logic                       out_ready;
    logic                       out_sop;
    logic                       out_eop;
    logic [DATA_W-1:0]          out_data;
    logic [2:0]                 out_prio;

    modport master (
        input  fifo_ready, fifo_sop, fifo_eop, fifo_data, out_ready,
        output next_data, out_vld, out_sop, out_eop, out_data, out_prio
    );

    modport slave (
        output fifo_ready, fifo_sop, fifo_eop, fifo_data, out_ready,
        input  next_data, out_vld, out_sop, out_eop, out_data, out_prio
    );
endinterface

// File: rtl/prio_fifo_sched.sv
// Egress scheduler: strict-priority packet selection with an aging boost,
// word-by-word pop of the granted FIFO into a one-stage registered output.
module prio_fifo_sched #(
    parameter int DATA_W       = 16,
    parameter int NUM_PRIO     = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    prio_fifo_sched_if.master bus,
    output logic              sop_err
);
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int PRIO_W = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state;
    logic [PRIO_W-1:0] grant;
    logic [CNT_W-1:0]  wait_cnt [NUM_PRIO];

    logic [PRIO_W-1:0] aged_idx;
    logic [PRIO_W-1:0] ready_idx;
    logic              any_aged;
    logic              any_ready;
    logic [PRIO_W-1:0] win;
    logic [PRIO_W-1:0] sel;
    logic              head_sop;
    logic              head_eop;
    logic [DATA_W-1:0] head_data;
    logic              pop;
    logic              orphan;
    logic              start;

    // Scanning from the top down leaves the lowest ready index in each class.
    always_comb begin
        aged_idx  = '0;
        ready_idx = '0;
        any_aged  = 1'b0;
        any_ready = 1'b0;
        for (int i = NUM_PRIO - 1; i >= 0; i--) begin
            if (bus.fifo_ready[i]) begin
                ready_idx = PRIO_W'(i);
                any_ready = 1'b1;
                if (wait_cnt[i] >= LIMIT) begin
                    aged_idx = PRIO_W'(i);
                    any_aged = 1'b1;
                end
            end
        end
    end

    assign win       = any_aged ? aged_idx : ready_idx;
    assign sel       = (state == XFER) ? grant : win;
    assign head_sop  = bus.fifo_sop[sel];
    assign head_eop  = bus.fifo_eop[sel];
    assign head_data = bus.fifo_data[int'(sel) * DATA_W +: DATA_W];

    assign pop    = rst && (state == XFER) && bus.fifo_ready[grant]
                    && (!bus.out_vld || bus.out_ready);
    assign orphan = rst && (state == IDLE) && any_ready && !head_sop;
    assign start  = (state == IDLE) && any_ready && head_sop;

    always_comb begin
        bus.next_data = '0;
        if (pop) begin
            bus.next_data[grant] = 1'b1;
        end else if (orphan) begin
            bus.next_data[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= '0;
            for (int j = 0; j < NUM_PRIO; j++) begin
                wait_cnt[j] <= '0;
            end
            bus.out_vld  <= 1'b0;
            bus.out_sop  <= 1'b0;
            bus.out_eop  <= 1'b0;
            bus.out_data <= '0;
            bus.out_prio <= '0;
            sop_err      <= 1'b0;
        end else begin
            if (pop) begin
                bus.out_vld  <= 1'b1;
                bus.out_sop  <= head_sop;
                bus.out_eop  <= head_eop;
                bus.out_data <= head_data;
                bus.out_prio <= 3'(grant);
            end else if (bus.out_ready) begin
                bus.out_vld  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        grant <= win;
                        state <= XFER;
                        // Queues left waiting age toward the boost; the winner starts over.
                        for (int j = 0; j < NUM_PRIO; j++) begin
                            if (PRIO_W'(j) == win) begin
                                wait_cnt[j] <= '0;
                            end else if (bus.fifo_ready[j] && wait_cnt[j] < LIMIT) begin
                                wait_cnt[j] <= wait_cnt[j] + CNT_W'(1);
                            end
                        end
                    end else if (orphan) begin
                        sop_err <= 1'b1;
                    end
                end
                XFER: begin
                    if (pop && head_eop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/prio_fifo_sched.md
Name: prio_fifo_sched

Overview:
- Egress scheduler sitting between the 8 per-priority packet FIFOs of one port and the SRAM write path.
- Picks one FIFO per packet using strict priority with an anti-starvation aging boost.
- Pops the chosen FIFO word by word through its next_data strobe.
- Forwards each word through a one-stage registered valid/ready output; packets are never interleaved.

Parameters:
- DATA_W, 16, payload width of each FIFO word (256 in production).
- NUM_PRIO, 8, number of priority FIFOs; index 0 is highest priority.
- STARVE_LIMIT, 15, number of packets granted to other queues while a queue waits before that queue is boosted.

Ports:
- clk  input  1  single clock domain.
- rst  input  1  asynchronous, active-low reset.
- fifo_ready  input  NUM_PRIO  bit i set: FIFO i has a word at its head.
- fifo_sop  input  NUM_PRIO  head-word start-of-packet flag, per FIFO.
- fifo_eop  input  NUM_PRIO  head-word end-of-packet flag, per FIFO.
- fifo_data  input  NUM_PRIO*DATA_W  head-word payloads; FIFO i occupies bits [i*DATA_W +: DATA_W].
- next_data  output  NUM_PRIO  one-hot pop strobe; combinational, at most one bit high.
- out_vld  output  1  output word valid.
- out_ready  input  1  downstream accepts the word when out_vld && out_ready.
- out_sop  output  1  output word start-of-packet flag.
- out_eop  output  1  output word end-of-packet flag.
- out_data  output  DATA_W  output word payload.
- out_prio  output  3  index of the source FIFO of the current output word.
- sop_err  output  1  sticky: a head word without sop was found while idle.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant=0.
  - All wait counters=0.
  - out_vld=0, out_sop=0, out_eop=0, out_data=0, out_prio=0, sop_err=0.
  - next_data=0.
  - A reset in mid-packet abandons the packet; no partial word is presented after reset.
- FSM states: IDLE, XFER.
- IDLE, candidate selection:
  - Candidates are all i with fifo_ready[i]=1.
  - Aged candidates (wait_cnt[i] >= STARVE_LIMIT) beat non-aged ones.
  - Within each class, the lowest index wins.
- IDLE, winner w has fifo_sop[w]=1:
  - Register grant=w and go to XFER.
  - No pop in this cycle.
- IDLE, winner w has fifo_sop[w]=0 (orphan word):
  - Pulse next_data[w] to discard the word, set sop_err, stay in IDLE.
  - Wait counters are not updated.
- Wait counters, updated at each grant:
  - Every queue j≠w with fifo_ready[j]=1 increments wait_cnt[j], saturating at STARVE_LIMIT.
  - wait_cnt[w] clears to 0.
- XFER, pop condition: fifo_ready[grant] && (!out_vld || out_ready).
- XFER, on a pop:
  - next_data[grant]=1 in the same cycle.
  - At the next edge, the output register loads {fifo_sop, fifo_eop, fifo_data} of grant, with out_vld=1 and out_prio=grant.
- XFER, no pop but out_ready=1: out_vld clears at the next edge.
- Output stall: out_vld=1 && out_ready=0 holds every out_* value stable.
- Popped word has eop=1: return to IDLE at the same edge; an eop word does not also trigger a new grant in that cycle.
- Underrun (fifo_ready[grant]=0 during XFER):
  - Stay in XFER, hold grant, no pop.
  - Other queues are not served until the eop word is popped.
- Single-word packet (sop=eop=1): one pop, then back to IDLE.
- Latency, FIFO idle-to-output:
  - fifo_ready rises in cycle 0 (IDLE).
  - Grant registers at edge 1.
  - next_data is high in cycle 1.
  - out_vld is high from edge 2.
- Throughput: one word per cycle with out_ready held at 1; one bubble cycle between back-to-back packets (IDLE arbitration).
- Arithmetic: wait counters are $clog2(STARVE_LIMIT+1) bits wide and saturating, never wrapping; out_prio is the zero-extended grant.

Test Plan:
- Reset: rst=0 for 3 cycles with all inputs random -> every output 0, next_data=0, sop_err=0.
- Priority: FIFO 5 and FIFO 2 each hold a 3-word packet, out_ready=1 -> FIFO 2's words emerge first (out_prio=2, sop on word 1, eop on word 3), one idle cycle, then FIFO 5's; first out_vld appears 2 cycles after fifo_ready rises.
- Backpressure: out_ready low for 4 cycles mid-packet -> out_data held, next_data=0 throughout the stall, no word lost or duplicated.
- Aging: FIFO 0 refilled continuously, FIFO 7 ready from the start, STARVE_LIMIT=15 -> after 15 FIFO-0 packets, FIFO 7 is granted next.
- Underrun plus competition: FIFO 3 goes empty after word 2 of 4 while FIFO 0 becomes ready -> grant stays on FIFO 3 until its eop, then FIFO 0 is served.
- Orphan word and reset: FIFO 1 head has sop=0 while IDLE -> one next_data[1] pulse, sop_err=1. Then assert rst mid-packet -> out_vld=0 immediately and sop_err cleared.
